cpu_req_master: RTL and testbench

CPU-side request initiator for the L1/L2 cache hierarchy. Accepts read and write commands from a host or sequencer over a valid/ready command port and queues them. It issues them one at a time on the L1 `cpu_*` interface, holding each strobe until `cpu_ready` or a timeout. Each completion returns in order on a valid/ready response port. It replaces hand-driven CPU stimulus in system benches and is the synthesizable front end for future core integration.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/cpu_req_master.sv | 185 ++++++++++++++++++
 tb/tb_cpu_req_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the CPU-side cache request path: default widths,
// the request FSM encoding and the queued command record.
package cache_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } req_state_t;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cpu_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push and a pop in the same
// cycle are both honoured, and pushes into a full queue are dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/cpu_req_master.sv
// Queues host read/write commands and issues them one at a time to L1,
// holding each strobe until cpu_ready or timeout, returning in-order responses.
module cpu_req_master
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic                  cpu_read,
    output logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] cpu_data_out,
    input  logic                  cpu_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_write,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [15:0]           req_count,
    output logic [7:0]            timeout_count,
    output logic [1:0]            dbg_state
);

    localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; a valid source holds its payload stable until then.

    logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]            fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        head_write;
    logic [ADDR_WIDTH-1:0]       head_addr;
    logic [DATA_WIDTH-1:0]       head_wdata;

    req_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_WIDTH-1:0] cpu_wdata_q, cpu_wdata_d;
    logic                  cpu_read_q, cpu_read_d;
    logic                  cpu_write_q, cpu_write_d;
    logic                  cur_write_q, cur_write_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [15:0]           req_count_q, req_count_d;
    logic [7:0]            timeout_count_q, timeout_count_d;

    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;
    assign {head_write, head_addr, head_wdata} = fifo_head;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cmd_write, cmd_addr, cmd_wdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cpu_addr_q      <= '0;
            cpu_wdata_q     <= '0;
            cpu_read_q      <= 1'b0;
            cpu_write_q     <= 1'b0;
            cur_write_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_timeout_q   <= 1'b0;
            cnt_q           <= '0;
            req_count_q     <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            cpu_addr_q      <= cpu_addr_d;
            cpu_wdata_q     <= cpu_wdata_d;
            cpu_read_q      <= cpu_read_d;
            cpu_write_q     <= cpu_write_d;
            cur_write_q     <= cur_write_d;
            rsp_data_q      <= rsp_data_d;
            rsp_timeout_q   <= rsp_timeout_d;
            cnt_q           <= cnt_d;
            req_count_q     <= req_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // cpu_ready on the last allowed cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_WAIT;
            ST_WAIT: if (cpu_ready || cnt_q == TO_LAST) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop        = 1'b0;
        cpu_addr_d      = cpu_addr_q;
        cpu_wdata_d     = cpu_wdata_q;
        cpu_read_d      = cpu_read_q;
        cpu_write_d     = cpu_write_q;
        cur_write_d     = cur_write_q;
        rsp_data_d      = rsp_data_q;
        rsp_timeout_d   = rsp_timeout_q;
        cnt_d           = cnt_q;
        req_count_d     = req_count_q;
        timeout_count_d = timeout_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    cpu_addr_d    = head_addr;
                    cpu_wdata_d   = head_wdata;
                    cur_write_d   = head_write;
                    cpu_read_d    = !head_write;
                    cpu_write_d   = head_write;
                    cnt_d         = '0;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cpu_ready) begin
                    cpu_read_d    = 1'b0;
                    cpu_write_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_data_d    = cur_write_q ? '0 : cpu_data_out;
                end else if (cnt_q == TO_LAST) begin
                    cpu_read_d    = 1'b0;
                    cpu_write_d   = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (req_count_q != 16'hFFFF) req_count_d = req_count_q + 16'd1;
                    if (rsp_timeout_q && timeout_count_q != 8'hFF)
                        timeout_count_d = timeout_count_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign cpu_addr      = cpu_addr_q;
    assign cpu_data_in   = cpu_wdata_q;
    assign cpu_read      = cpu_read_q;
    assign cpu_write     = cpu_write_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_addr      = cpu_addr_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_write     = cur_write_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = (state_q != ST_IDLE) || (fifo_count != '0);
    assign req_count     = req_count_q;
    assign timeout_count = timeout_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cpu_req_master.sv
// Directed bench for cpu_req_master: a default-timeout instance for the main
// flows and an 8-cycle-timeout instance for the timeout boundary.
module tb_cpu_req_master;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, b_cmd_valid;
  logic        cmd_write;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [7:0]  cpu_data_out;
  logic        cpu_ready, b_cpu_ready;
  logic        rsp_ready, b_rsp_ready;

  logic        cmd_ready, b_cmd_ready;
  logic [10:0] cpu_addr, b_cpu_addr;
  logic [7:0]  cpu_data_in, b_cpu_data_in;
  logic        cpu_read, b_cpu_read;
  logic        cpu_write, b_cpu_write;
  logic        rsp_valid, b_rsp_valid;
  logic [10:0] rsp_addr, b_rsp_addr;
  logic [7:0]  rsp_data, b_rsp_data;
  logic        rsp_write, b_rsp_write;
  logic        rsp_timeout, b_rsp_timeout;
  logic        busy, b_busy;
  logic [15:0] req_count, b_req_count;
  logic [7:0]  timeout_count, b_timeout_count;
  logic [1:0]  dbg_state, b_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_req_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .busy(busy), .req_count(req_count), .timeout_count(timeout_count),
    .dbg_state(dbg_state)
  );

  cpu_req_master #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cpu_addr(b_cpu_addr), .cpu_data_in(b_cpu_data_in), .cpu_read(b_cpu_read),
    .cpu_write(b_cpu_write), .cpu_data_out(cpu_data_out), .cpu_ready(b_cpu_ready),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_addr(b_rsp_addr),
    .rsp_data(b_rsp_data), .rsp_write(b_rsp_write), .rsp_timeout(b_rsp_timeout),
    .busy(b_busy), .req_count(b_req_count), .timeout_count(b_timeout_count),
    .dbg_state(b_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command to the selected instance and wait (bounded) for the push edge.
  task automatic push(input bit sel, input logic w, input logic [10:0] a, input logic [7:0] d);
    int n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    if (sel) b_cmd_valid = 1'b1;
    else     cmd_valid   = 1'b1;
    #0;
    while (!(sel ? b_cmd_ready : cmd_ready) && n < 50) begin
      tick();
      n++;
    end
    check("push_accept", 32'(sel ? b_cmd_ready : cmd_ready), 32'd1);
    tick();
    cmd_valid   = 1'b0;
    b_cmd_valid = 1'b0;
  endtask

  // Ticks until the main instance raises a strobe; n = cycles spent waiting.
  task automatic wait_strobe(input string tag, output int n);
    n = 0;
    while (!(cpu_read || cpu_write) && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(cpu_read || cpu_write), 32'd1);
  endtask

  logic [7:0]  bdata [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [10:0] baddr [5] = '{11'h000, 11'h002, 11'h005, 11'h010, 11'h014};

  initial begin
    int n;
    cpu_cmd_t wr_cmd;

    rst = 1'b1; cmd_valid = 1'b1; b_cmd_valid = 1'b1;
    cmd_write = 1'b0; cmd_addr = 11'h007; cmd_wdata = 8'h00;
    cpu_data_out = 8'h00; cpu_ready = 1'b0; b_cpu_ready = 1'b0;
    rsp_ready = 1'b1; b_rsp_ready = 1'b1;

    // Reset held two cycles with a command offered
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_strobes", 32'({cpu_read, cpu_write}), 32'd0);
    check("rst_cpu_addr", 32'(cpu_addr), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_counts", 32'({req_count, timeout_count}), 32'd0);
    check("rst_b_cmd_ready", 32'(b_cmd_ready), 32'd0);
    cmd_valid = 1'b0; b_cmd_valid = 1'b0; rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("post_rst_no_push", 32'(busy), 32'd0);

    // Read miss, L1 answers after 12 strobe cycles
    push(1'b0, 1'b0, 11'h001, 8'h00);
    check("rd_strobe_not_yet", 32'(cpu_read), 32'd0);
    wait_strobe("rd_strobe_up", n);
    check("rd_strobe_latency", 32'(n), 32'd1);
    check("rd_cpu_addr", 32'(cpu_addr), 32'h001);
    check("rd_no_write", 32'(cpu_write), 32'd0);
    for (int i = 1; i < 12; i++) begin
      tick();
      check("rd_strobe_held", 32'(cpu_read), 32'd1);
    end
    cpu_ready = 1'b1; cpu_data_out = 8'hA5;
    tick();
    cpu_ready = 1'b0; cpu_data_out = 8'h00;
    check("rd_strobe_drop", 32'(cpu_read), 32'd0);
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_addr", 32'(rsp_addr), 32'h001);
    check("rd_rsp_data", 32'(rsp_data), 32'hA5);
    check("rd_rsp_write", 32'(rsp_write), 32'd0);
    check("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
    tick();
    check("rd_req_count", 32'(req_count), 32'd1);
    check("rd_rsp_done", 32'(rsp_valid), 32'd0);

    // Burst: first read goes in flight, the next four fill the queue
    push(1'b0, 1'b0, baddr[0], 8'h00);
    exp_q.push_back(baddr[0]);
    wait_strobe("burst_first_strobe", n);
    for (int k = 1; k < 5; k++) begin
      push(1'b0, 1'b0, baddr[k], 8'h00);
      exp_q.push_back(baddr[k]);
    end
    check("burst_full", 32'(cmd_ready), 32'd0);
    cmd_addr = 11'h3FF; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("burst_still_full", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    check("burst_stalled_strobe", 32'(cpu_read), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("burst_issue_addr", 32'(cpu_addr), 32'(exp_q[0]));
      cpu_ready = 1'b1; cpu_data_out = bdata[k];
      tick();
      cpu_ready = 1'b0;
      check("burst_rsp_valid", 32'(rsp_valid), 32'd1);
      check("burst_rsp_addr", 32'(rsp_addr), 32'(exp_q.pop_front()));
      check("burst_rsp_data", 32'(rsp_data), 32'(bdata[k]));
      check("burst_gap_low", 32'(cpu_read), 32'd0);
      if (k < 4) begin
        wait_strobe("burst_next_strobe", n);
        check("burst_gap_cycles", 32'(n), 32'd2);
      end
    end
    tick();
    check("burst_req_count", 32'(req_count), 32'd6);
    check("burst_idle", 32'(busy), 32'd0);

    // Write 0x101 / 0x3C; read data from L1 must be ignored
    wr_cmd = '{write: 1'b1, addr: 11'h101, wdata: 8'h3C};
    push(1'b0, wr_cmd.write, wr_cmd.addr, wr_cmd.wdata);
    wait_strobe("wr_strobe_up", n);
    check("wr_cpu_write", 32'(cpu_write), 32'd1);
    check("wr_cpu_read", 32'(cpu_read), 32'd0);
    check("wr_cpu_data_in", 32'(cpu_data_in), 32'h3C);
    check("wr_cpu_addr", 32'(cpu_addr), 32'h101);
    tick(); tick();
    cpu_ready = 1'b1; cpu_data_out = 8'hFF;
    tick();
    cpu_ready = 1'b0;
    check("wr_rsp_write", 32'(rsp_write), 32'd1);
    check("wr_rsp_data", 32'(rsp_data), 32'h00);
    check("wr_rsp_addr", 32'(rsp_addr), 32'h101);
    tick();
    check("wr_req_count", 32'(req_count), 32'd7);

    // Response backpressure for 5 cycles
    rsp_ready = 1'b0;
    push(1'b0, 1'b0, 11'h0AA, 8'h00);
    wait_strobe("bp_strobe_up", n);
    tick();
    cpu_ready = 1'b1; cpu_data_out = 8'h77;
    tick();
    cpu_ready = 1'b0; cpu_data_out = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_fields", 32'({rsp_addr, rsp_data, rsp_write, rsp_timeout}),
            32'({11'h0AA, 8'h77, 1'b0, 1'b0}));
      check("bp_strobe_low", 32'({cpu_read, cpu_write}), 32'd0);
      tick();
    end
    check("bp_count_held", 32'(req_count), 32'd7);
    rsp_ready = 1'b1;
    tick();
    check("bp_req_count", 32'(req_count), 32'd8);

    // Reset during a later WAIT with one command still queued
    push(1'b0, 1'b0, 11'h123, 8'h00);
    wait_strobe("rw_strobe_up", n);
    push(1'b0, 1'b0, 11'h124, 8'h00);
    check("rw_in_wait", 32'(cpu_read), 32'd1);
    rst = 1'b1;
    tick();
    check("rw_strobe_drop", 32'({cpu_read, cpu_write}), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_req_count", 32'(req_count), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rw_quiet", 32'({cpu_read, cpu_write, rsp_valid, busy}), 32'd0);
    end

    // Timeout instance: never ready, strobe held exactly 8 cycles
    cpu_data_out = 8'hEE;
    push(1'b1, 1'b0, 11'h033, 8'h00);
    tick();
    check("to_strobe_up", 32'(b_cpu_read), 32'd1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!b_cpu_read) break;
      n++;
    end
    check("to_strobe_cycles", 32'(n), 32'd8);
    check("to_rsp_valid", 32'(b_rsp_valid), 32'd1);
    check("to_rsp_timeout", 32'(b_rsp_timeout), 32'd1);
    check("to_rsp_data", 32'(b_rsp_data), 32'h00);
    check("to_rsp_addr", 32'(b_rsp_addr), 32'h033);
    tick();
    check("to_timeout_count", 32'(b_timeout_count), 32'd1);
    check("to_req_count", 32'(b_req_count), 32'd1);

    // Ready on the 8th strobe cycle beats the timeout
    push(1'b1, 1'b0, 11'h044, 8'h00);
    tick();
    check("to8_strobe_up", 32'(b_cpu_read), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to8_strobe_held", 32'(b_cpu_read), 32'd1);
    end
    b_cpu_ready = 1'b1; cpu_data_out = 8'h5C;
    tick();
    b_cpu_ready = 1'b0;
    check("to8_rsp_valid", 32'(b_rsp_valid), 32'd1);
    check("to8_rsp_timeout", 32'(b_rsp_timeout), 32'd0);
    check("to8_rsp_data", 32'(b_rsp_data), 32'h5C);
    tick();
    check("to8_timeout_count", 32'(b_timeout_count), 32'd1);
    check("to8_req_count", 32'(b_req_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
